pooling_ctrl: RTL
=================

POOLING_CTRL -- requirements
Module: pooling_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width (IEEE-754 single bits).
REQ-002 SHALL have parameter TOTAL_FEATURE, default 4, number of feature maps interleaved per row.
REQ-003 SHALL have parameter TOTAL_ROW, default 6, number of input rows per frame (even).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a frame.
REQ-007 SHALL have port busy  out  1  high from the cycle after an accepted start until done.
REQ-008 SHALL have port done  out  1  one-cycle pulse when the frame completes.
REQ-009 SHALL have port src_valid  in  1  source word available.
REQ-010 SHALL have port src_ready  out  1  controller accepts a word this cycle.
REQ-011 SHALL have port src_data  in  DATA_WIDTH  source word.
REQ-012 SHALL have port arr_input_valid  out  1  window trigger to pooling array.
REQ-013 SHALL have port arr_data  out  DATA_WIDTH  word to pooling array data input.
REQ-014 SHALL have port arr_feature_idx  out  2  feature index to pooling array.
REQ-015 SHALL have port arr_feature_row  out  3  row index to pooling array.
REQ-016 SHALL have port arr_output_valid  in  1  pooling array result strobe.
REQ-017 SHALL have port arr_data_out  in  DATA_WIDTH  pooling array result.
REQ-018 SHALL have ports dst_valid  out  1; dst_data  out  DATA_WIDTH; dst_feature  out  2; dst_row  out  2: completed 2x2 pooled output, its feature and output row.

Function
REQ-019 SHALL implement states IDLE, LOAD, FIRE, FEED0, FEED1, WAIT, RESULT.
REQ-020 IDLE: start -> LOAD, feature and row counters cleared to 0; start in any other state ignored.
REQ-021 LOAD: src_ready=1 while fewer than 2 words held; transfer on src_valid&&src_ready; words held as w0 then w1; -> FIRE the cycle after the second transfer.
REQ-022 FIRE: arr_input_valid=1 for exactly one cycle; -> FEED0.
REQ-023 FEED0: arr_data=w0; -> FEED1.  FEED1: arr_data=w1; -> WAIT.  WAIT: arr_data=0; -> RESULT.
REQ-024 RESULT: remain until arr_output_valid=1; then advance counters and -> LOAD, or -> IDLE with done=1 on the last window.
REQ-025 arr_feature_idx/arr_feature_row SHALL equal the counters and stay constant from FIRE through the RESULT cycle in which arr_output_valid is seen.
REQ-026 Counter order: feature increments 0..TOTAL_FEATURE-1, wraps to 0 and increments row; frame ends after row TOTAL_ROW-1, feature TOTAL_FEATURE-1.
REQ-027 On arr_output_valid in RESULT with odd row: dst_valid=1 same cycle, dst_data=arr_data_out, dst_feature=feature counter, dst_row=row>>1; even rows produce no dst_valid.
REQ-028 arr_data SHALL be 0 outside FEED0/FEED1; arr_input_valid 0 outside FIRE.
REQ-029 Minimum window period 7 cycles with src_valid held high; frame consumes 2*TOTAL_FEATURE*TOTAL_ROW words (48 default) and emits TOTAL_FEATURE*TOTAL_ROW/2 dst words (12 default).
REQ-030 src_valid low in LOAD stalls indefinitely with no array activity; partially held word retained.
REQ-031 arr_output_valid outside RESULT SHALL be ignored.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, counters 0, held words 0, and busy, done, src_ready, arr_input_valid, dst_valid, arr_data, dst_data, arr_feature_idx, arr_feature_row, dst_feature, dst_row all 0, including mid-frame.

Verification
REQ-033 Frame with src_valid always 1, model array returning 3-cycle-later strobe -> 48 words accepted, 12 dst_valid pulses, dst (row,feature) order (0,0)..(0,3),(1,0)..(2,3), one done pulse.
REQ-034 Single window: w0=0x3F800000, w1=0x40000000 -> arr_input_valid in FIRE, arr_data 0x3F800000 then 0x40000000 on the next two cycles.
REQ-035 src_valid toggling 1,0,0,1 in LOAD -> FIRE only after second accept; no arr_input_valid during gap.
REQ-036 start pulsed while busy -> ignored; counters and outputs unchanged.
REQ-037 rst_n low during FEED1 of row 3 -> all outputs 0 same cycle; after release, new start processes a full frame from row 0.
REQ-038 arr_output_valid delayed 5 cycles in RESULT -> feature_idx/row held stable, no counter advance until strobe.

Source files
------------

// File: rtl/pooling_ctrl.sv
// Sequencer between a word stream and a 2x2 pooling array: loads two words per window,
// fires the array, feeds the pair, waits for the result and forwards odd-row results.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | collecting w0 then w1 from the source
// FIRE   | window trigger to the array
// FEED0  | w0 on arr_data
// FEED1  | w1 on arr_data
// WAIT   | array settling, arr_data cleared
// RESULT | waiting for the array result strobe
module pooling_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int TOTAL_FEATURE = 4,
  parameter int TOTAL_ROW     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  arr_input_valid,
  output logic [DATA_WIDTH-1:0] arr_data,
  output logic [1:0]            arr_feature_idx,
  output logic [2:0]            arr_feature_row,
  input  logic                  arr_output_valid,
  input  logic [DATA_WIDTH-1:0] arr_data_out,
  output logic                  dst_valid,
  output logic [DATA_WIDTH-1:0] dst_data,
  output logic [1:0]            dst_feature,
  output logic [1:0]            dst_row
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FIRE   = 3'd2,
    FEED0  = 3'd3,
    FEED1  = 3'd4,
    WAIT   = 3'd5,
    RESULT = 3'd6
  } state_t;

  localparam logic [1:0] LAST_FEAT = 2'(TOTAL_FEATURE - 1);
  localparam logic [2:0] LAST_ROW  = 3'(TOTAL_ROW - 1);

  state_t                state;
  logic [1:0]            feat_cnt;
  logic [2:0]            row_cnt;
  logic                  held;
  logic [DATA_WIDTH-1:0] w0;
  logic [DATA_WIDTH-1:0] w1;
  logic                  last_win;
  logic                  result_hit;

  assign last_win   = (feat_cnt == LAST_FEAT) && (row_cnt == LAST_ROW);
  assign result_hit = (state == RESULT) && arr_output_valid;

  assign arr_feature_idx = feat_cnt;
  assign arr_feature_row = row_cnt;

  // Result forwarding is same-cycle with the array strobe; only odd rows close a 2x2 block.
  assign dst_valid   = result_hit && row_cnt[0];
  assign dst_data    = dst_valid ? arr_data_out : '0;
  assign dst_feature = dst_valid ? feat_cnt : 2'd0;
  assign dst_row     = dst_valid ? row_cnt[2:1] : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      feat_cnt        <= 2'd0;
      row_cnt         <= 3'd0;
      held            <= 1'b0;
      w0              <= '0;
      w1              <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      src_ready       <= 1'b0;
      arr_input_valid <= 1'b0;
      arr_data        <= '0;
    end else begin
      done            <= 1'b0;
      arr_input_valid <= 1'b0;
      arr_data        <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            feat_cnt  <= 2'd0;
            row_cnt   <= 3'd0;
            held      <= 1'b0;
            busy      <= 1'b1;
            src_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (src_valid && src_ready) begin
            if (!held) begin
              w0   <= src_data;
              held <= 1'b1;
            end else begin
              w1              <= src_data;
              held            <= 1'b0;
              src_ready       <= 1'b0;
              arr_input_valid <= 1'b1;
              state           <= FIRE;
            end
          end
        end
        FIRE: begin
          arr_data <= w0;
          state    <= FEED0;
        end
        FEED0: begin
          arr_data <= w1;
          state    <= FEED1;
        end
        FEED1: state <= WAIT;
        WAIT:  state <= RESULT;
        RESULT: begin
          if (arr_output_valid) begin
            if (last_win) begin
              state    <= IDLE;
              done     <= 1'b1;
              busy     <= 1'b0;
              feat_cnt <= 2'd0;
              row_cnt  <= 3'd0;
            end else begin
              state     <= LOAD;
              src_ready <= 1'b1;
              if (feat_cnt == LAST_FEAT) begin
                feat_cnt <= 2'd0;
                row_cnt  <= row_cnt + 3'd1;
              end else begin
                feat_cnt <= feat_cnt + 2'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
